// File: rtl/axis_downsizer_if.sv
// axis_downsizer_if: AXI4-Stream bundle; tlast exists only when AXIS_DOWNSIZER_TLAST_EN is defined.
interface axis_downsizer_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
`ifdef AXIS_DOWNSIZER_TLAST_EN
  logic tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
`else
  modport master(output tdata, tvalid, input tready);
  modport slave(input tdata, tvalid, output tready);
`endif
endinterface

// File: rtl/axis_downsizer.sv
// axis_downsizer: splits wide AXI4-Stream words into narrow ones, LS slice first; optional tlast via AXIS_DOWNSIZER_TLAST_EN.
module axis_downsizer #(
  parameter int S_AXIS_TDATA_WIDTH = 96,
  parameter int M_AXIS_TDATA_WIDTH = 32
) (
  input  logic aclk,
  input  logic areset,
  input  logic [15:0] cfg_data,
  axis_downsizer_if.slave  s_axis,
  axis_downsizer_if.master m_axis
);
  localparam int RATIO = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH;
  localparam int CW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_MAX = CW'(RATIO - 1);
  logic [S_AXIS_TDATA_WIDTH-1:0] data_reg;
  logic [CW-1:0] cntr_reg, last_reg, cfg_last;
  logic valid_reg, out_beat, final_beat, accept, unused_cfg;
  assign unused_cfg = ^cfg_data[15:CW];
  assign cfg_last = cfg_data[CW-1:0] > LAST_MAX ? LAST_MAX : cfg_data[CW-1:0];
  assign out_beat = valid_reg & m_axis.tready;
  assign final_beat = out_beat & (cntr_reg == last_reg);
  assign s_axis.tready = ~areset & (~valid_reg | final_beat);
  assign accept = s_axis.tvalid & s_axis.tready;
  assign m_axis.tvalid = valid_reg;
  assign m_axis.tdata = data_reg[M_AXIS_TDATA_WIDTH-1:0];
  // a final beat that coincides with an accept reloads directly, so no bubble
  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_reg <= 1'b0;
      cntr_reg <= '0;
      last_reg <= '0;
    end else if (accept) begin
      data_reg <= s_axis.tdata;
      valid_reg <= 1'b1;
      cntr_reg <= '0;
      last_reg <= cfg_last;
    end else if (final_beat) begin
      valid_reg <= 1'b0;
    end else if (out_beat) begin
      data_reg <= data_reg >> M_AXIS_TDATA_WIDTH;
      cntr_reg <= cntr_reg + CW'(1);
    end
  end
`ifdef AXIS_DOWNSIZER_TLAST_EN
  logic tlast_reg;
  always_ff @(posedge aclk) begin
    if (areset) tlast_reg <= 1'b0;
    else if (accept) tlast_reg <= s_axis.tlast;
  end
  assign m_axis.tlast = tlast_reg & (cntr_reg == last_reg) & valid_reg;
`endif
endmodule

// File: tb/tb_axis_downsizer.sv
// tb_axis_downsizer: directed checks of axis_downsizer (96->32) plus a random backpressure scoreboard.
module tb_axis_downsizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] cfg = 16'd2;
  int total = 0;
  int bad = 0;
  localparam logic [95:0] WA = 96'h333333332222222211111111;
  localparam logic [95:0] WB = 96'h666666665555555544444444;
  axis_downsizer_if #(.W(96)) s_if();
  axis_downsizer_if #(.W(32)) m_if();
  axis_downsizer #(.S_AXIS_TDATA_WIDTH(96), .M_AXIS_TDATA_WIDTH(32)) dut (
    .aclk(clk), .areset(rst), .cfg_data(cfg), .s_axis(s_if), .m_axis(m_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic ev, input logic [31:0] ed, input logic er);
    #1;
    chk({tag, "_valid"}, 96'(m_if.tvalid), 96'(ev));
    if (ev) chk({tag, "_data"}, 96'(m_if.tdata), 96'(ed));
    chk({tag, "_sready"}, 96'(s_if.tready), 96'(er));
    @(negedge clk);
  endtask
  logic [31:0] q[$];
  logic [31:0] held, exp_d;
  logic stalled, pend, acc, beat;
  int acc_words;
  initial begin
    s_if.tvalid = 1'b1;
    s_if.tdata = WA;
`ifdef AXIS_DOWNSIZER_TLAST_EN
    s_if.tlast = 1'b0;
`endif
    m_if.tready = 1'b1;
    @(negedge clk);
    repeat (3) cyc("rst", 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    cyc("acc", 1'b0, 32'h0, 1'b1);
    s_if.tdata = WB;
    cyc("c1", 1'b1, 32'h11111111, 1'b0);
    cyc("c2", 1'b1, 32'h22222222, 1'b0);
    cyc("c3", 1'b1, 32'h33333333, 1'b1);
    s_if.tvalid = 1'b0;
    cyc("c4", 1'b1, 32'h44444444, 1'b0);
    cyc("c5", 1'b1, 32'h55555555, 1'b0);
    cyc("c6", 1'b1, 32'h66666666, 1'b1);
    cyc("c_idle", 1'b0, 32'h0, 1'b1);
    cfg = 16'd1;
    s_if.tvalid = 1'b1;
    s_if.tdata = WA;
    cyc("p0", 1'b0, 32'h0, 1'b1);
    s_if.tdata = WB;
    cfg = 16'd0;
    cyc("p1", 1'b1, 32'h11111111, 1'b0);
    cyc("p2", 1'b1, 32'h22222222, 1'b1);
    s_if.tvalid = 1'b0;
    cyc("p3", 1'b1, 32'h44444444, 1'b1);
    cyc("p_idle", 1'b0, 32'h0, 1'b1);
    cfg = 16'd3;
    s_if.tvalid = 1'b1;
    s_if.tdata = WA;
    cyc("cl0", 1'b0, 32'h0, 1'b1);
    s_if.tvalid = 1'b0;
    cyc("cl1", 1'b1, 32'h11111111, 1'b0);
    cyc("cl2", 1'b1, 32'h22222222, 1'b0);
    cyc("cl3", 1'b1, 32'h33333333, 1'b1);
    cyc("cl_idle", 1'b0, 32'h0, 1'b1);
    cfg = 16'd2;
    s_if.tvalid = 1'b1;
    cyc("r0", 1'b0, 32'h0, 1'b1);
    s_if.tvalid = 1'b0;
    cyc("r1", 1'b1, 32'h11111111, 1'b0);
    rst = 1'b1;
    m_if.tready = 1'b0;
    cyc("r2", 1'b1, 32'h22222222, 1'b0);
    rst = 1'b0;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata = WB;
    cyc("r3", 1'b0, 32'h0, 1'b1);
    s_if.tvalid = 1'b0;
    cyc("r4", 1'b1, 32'h44444444, 1'b0);
    cyc("r5", 1'b1, 32'h55555555, 1'b0);
    cyc("r6", 1'b1, 32'h66666666, 1'b1);
    cyc("r_idle", 1'b0, 32'h0, 1'b1);
`ifdef AXIS_DOWNSIZER_TLAST_EN
    for (int k = 0; k < 2; k++) begin
      s_if.tlast = (k == 0);
      s_if.tvalid = 1'b1;
      s_if.tdata = WA;
      #1;
      chk("tl_idle", 96'(m_if.tlast), 96'(0));
      @(negedge clk);
      s_if.tvalid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        #1;
        chk("tl_beat", 96'(m_if.tlast), 96'((k == 0) && (j == 2)));
        @(negedge clk);
      end
    end
    s_if.tlast = 1'b0;
`endif
    stalled = 1'b0;
    pend = 1'b0;
    acc_words = 0;
    held = '0;
    for (int c = 0; c < 20000 && (acc_words < 1000 || q.size() > 0); c++) begin
      if (!pend) begin
        s_if.tvalid = (acc_words < 1000) && ($urandom_range(0, 1) == 1);
        s_if.tdata = {$urandom, $urandom, $urandom};
      end
      m_if.tready = ($urandom_range(0, 1) == 1);
      #1;
      if (stalled) begin
        chk("bp_hold_valid", 96'(m_if.tvalid), 96'(1));
        chk("bp_hold_data", 96'(m_if.tdata), 96'(held));
      end
      acc = s_if.tvalid & s_if.tready;
      beat = m_if.tvalid & m_if.tready;
      if (beat) begin
        chk("bp_q_nonempty", 96'(q.size() != 0), 96'(1));
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          chk("bp_data", 96'(m_if.tdata), 96'(exp_d));
        end
      end
      stalled = m_if.tvalid & ~m_if.tready;
      held = m_if.tdata;
      pend = s_if.tvalid & ~acc;
      if (acc) begin
        for (int k = 0; k < 3; k++) q.push_back(s_if.tdata[32*k +: 32]);
        acc_words++;
      end
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    chk("bp_words", 96'(acc_words), 96'(1000));
    chk("bp_leftover", 96'(q.size()), 96'(0));
    #1;
    chk("bp_end_valid", 96'(m_if.tvalid), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
